// File: rtl/knight_cmd_pkg.sv
// Shared command-link types and constants for ble_cmd_link, cmd_proc and TourCmd.
package knight_cmd_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CMD_W  = 16;
   localparam int unsigned TMO_W  = 20;

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } rx_state_t;

   // A command as it travels over the link: high byte first, then low byte
   typedef struct packed {
      logic [BYTE_W-1:0] hi;
      logic [BYTE_W-1:0] lo;
   } cmd_word_t;

   localparam logic [3:0] CMD_CAL     = 4'h2;
   localparam logic [3:0] CMD_MOVE    = 4'h4;
   localparam logic [3:0] CMD_MOVE_FF = 4'h5;
   localparam logic [3:0] CMD_TOUR    = 4'h6;

   localparam logic [BYTE_W-1:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/ble_cmd_link_if.sv
// Byte/command/response signal bundle between the BLE UART, ble_cmd_link and cmd_proc.
interface ble_cmd_link_if;

   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done;
   logic        frame_err;

   // master: the link block itself
   modport master (
      input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
      output clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, frame_err
   );

   // slave: the UART pair plus cmd_proc surrounding the link
   modport slave (
      output rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
      input  clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, frame_err
   );

endinterface

// File: rtl/ble_cmd_link_resp_sched.sv
// Acknowledge scheduler: turns send_resp pulses into trmt pulses, one byte in flight
// plus at most one waiting request; extra requests while one waits are merged.
module ble_cmd_link_resp_sched (
   input  logic clk,
   input  logic rst_n,
   input  logic send_resp,
   input  logic tx_done,
   output logic trmt
);

   logic busy_q, busy_d;
   logic pend_q, pend_d;
   logic trmt_q, trmt_d;
   logic launch_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         pend_q <= 1'b0;
         trmt_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         pend_q <= pend_d;
         trmt_q <= trmt_d;
      end
   end

   // tx_done frees the transmitter in the same cycle so a waiting request launches at once
   always_comb begin
      launch_c = (pend_q | send_resp) & (~busy_q | tx_done) & ~trmt_q;
      trmt_d   = launch_c;
      busy_d   = trmt_q | (busy_q & ~tx_done);
      pend_d   = pend_q | send_resp;
      if (launch_c) begin
         // a fresh request arriving while the waiting one launches must wait its turn
         pend_d = pend_q & send_resp;
      end
   end

   assign trmt = trmt_q;

endmodule

// File: rtl/ble_cmd_link.sv
// BLE command link: assembles high/low UART bytes into 16-bit commands for cmd_proc
// and sends one acknowledge byte per send_resp. CMD_TIMEOUT_EN adds an inter-byte timeout.
module ble_cmd_link
   import knight_cmd_pkg::*;
#(
   parameter logic [BYTE_W-1:0] RESP_BYTE = RESP_ACK
`ifdef CMD_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CLKS = 1000000
`endif
) (
   input logic clk,
   input logic rst_n,
   ble_cmd_link_if.master bus
);

   rx_state_t state_q, state_d;
   cmd_word_t cmd_q, cmd_d;
   logic      cmd_rdy_q, cmd_rdy_d;
   logic      clr_rx_rdy_c;

`ifdef CMD_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             frame_err_q, frame_err_d;
   logic             timeout_c;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WAIT_HI;
         cmd_q     <= '0;
         cmd_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cmd_rdy_q <= cmd_rdy_d;
      end
   end

`ifdef CMD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         tmo_cnt_q   <= tmo_cnt_d;
         frame_err_q <= frame_err_d;
      end
   end
`endif

   // Byte-pair assembly; a low-byte capture sets cmd_rdy even if cleared the same cycle
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cmd_rdy_d    = cmd_rdy_q & ~bus.clr_cmd_rdy;
      clr_rx_rdy_c = 1'b0;
`ifdef CMD_TIMEOUT_EN
      timeout_c    = 1'b0;
      tmo_cnt_d    = '0;
`endif
      case (state_q)
         WAIT_HI: begin
            if (bus.rx_rdy) begin
               cmd_d.hi     = bus.rx_data;
               clr_rx_rdy_c = 1'b1;
               cmd_rdy_d    = 1'b0;
               state_d      = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (bus.rx_rdy) begin
               cmd_d.lo     = bus.rx_data;
               clr_rx_rdy_c = 1'b1;
               cmd_rdy_d    = 1'b1;
               state_d      = WAIT_HI;
            end
`ifdef CMD_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
               timeout_c = 1'b1;
               state_d   = WAIT_HI;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
`endif
         end
         default: state_d = WAIT_HI;
      endcase
`ifdef CMD_TIMEOUT_EN
      frame_err_d = timeout_c;
`endif
   end

   ble_cmd_link_resp_sched u_resp_sched (
      .clk       (clk),
      .rst_n     (rst_n),
      .send_resp (bus.send_resp),
      .tx_done   (bus.tx_done),
      .trmt      (bus.trmt)
   );

   assign bus.clr_rx_rdy = clr_rx_rdy_c;
   assign bus.cmd        = cmd_q;
   assign bus.cmd_rdy    = cmd_rdy_q;
   assign bus.tx_data    = RESP_BYTE;
`ifdef CMD_TIMEOUT_EN
   assign bus.frame_err  = frame_err_q;
`else
   assign bus.frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ble_cmd_link.sv
// Scoreboard bench for ble_cmd_link: randomized byte/response traffic against a
// cycle-arithmetic reference model; build with CMD_TIMEOUT_EN to cover the timeout.
module tb_ble_cmd_link;

   localparam int L = 6;   // UART transmit time in clocks (trmt -> tx_done)
`ifdef CMD_TIMEOUT_EN
   localparam int TMO = 16;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   trmt_seen = 0;
   int   done_at = -1;
   logic prev_rdy = 1'b0;

   // expected-event queues: cycle of the event (and value for commands)
   int          tq[$];
   int          cq_t[$];
   logic [15:0] cq_v[$];
   int          fq[$];

   // reference model state
   int          last_sched = -1000;
   bit          expect_lo = 0;
   logic [7:0]  hi_byte = 8'h00;
   int          lo_idle = 0;

   ble_cmd_link_if bus ();

`ifdef CMD_TIMEOUT_EN
   ble_cmd_link #(.TIMEOUT_CLKS(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
   ble_cmd_link dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transmitter model: one byte in flight for L clocks, at most one request waiting
   task automatic sched_resp(input int c);
      int n;
      if (last_sched > c + 1) return;
      if (last_sched == c + 1) n = c + L + 2;
      else n = (c + 1 > last_sched + L + 1) ? c + 1 : last_sched + L + 1;
      tq.push_back(n);
      last_sched = n;
   endtask

   // Drive one clock of inputs (called at posedge+1), update model, advance a clock
   task automatic step(input bit rv, input logic [7:0] d, input bit clr, input bit sr);
      bus.rx_rdy      = rv;
      bus.rx_data     = d;
      bus.clr_cmd_rdy = clr;
      bus.send_resp   = sr;
      if (sr) sched_resp(cyc);
      if (rv) begin
         if (!expect_lo) begin
            hi_byte   = d;
            expect_lo = 1;
         end else begin
            cq_t.push_back(cyc + 1);
            cq_v.push_back({hi_byte, d});
            expect_lo = 0;
         end
         lo_idle = 0;
      end else if (expect_lo) begin
         lo_idle++;
`ifdef CMD_TIMEOUT_EN
         if (lo_idle == TMO) begin
            fq.push_back(cyc + 1);
            expect_lo = 0;
            lo_idle   = 0;
         end
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit rnd_sr);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, rnd_sr && ($urandom_range(3) == 0));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.rx_rdy = 0; bus.rx_data = 0; bus.clr_cmd_rdy = 0; bus.send_resp = 0;
      tq.delete(); cq_t.delete(); cq_v.delete(); fq.delete();
      last_sched = -1000; expect_lo = 0; lo_idle = 0; done_at = -1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // UART transmitter: tx_done L clocks after each observed trmt
   always @(posedge clk) begin
      #1;
      bus.tx_done = rst_n && (done_at == cyc);
   end

   // Monitor: pop expected events whenever the DUT presents one
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rdy = 1'b0;
      end else begin
         chk("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(bus.rx_rdy));
         if (bus.trmt) begin
            trmt_seen++;
            chk("tx_data", 32'(bus.tx_data), 32'hA5);
            if (tq.size() == 0) chk("trmt_unexpected", 1, 0);
            else chk("trmt_cycle", cyc, tq.pop_front());
            done_at = cyc + L;
         end else if (tq.size() > 0 && tq[0] < cyc) begin
            chk("trmt_missing", cyc, tq.pop_front());
         end
         if (bus.cmd_rdy && !prev_rdy) begin
            if (cq_t.size() == 0) chk("cmd_rdy_unexpected", 1, 0);
            else begin
               chk("cmd_rdy_cycle", cyc, cq_t.pop_front());
               chk("cmd_value", 32'(bus.cmd), 32'(cq_v.pop_front()));
            end
         end else if (cq_t.size() > 0 && cq_t[0] < cyc) begin
            chk("cmd_rdy_missing", cyc, cq_t.pop_front());
            void'(cq_v.pop_front());
         end
         if (bus.frame_err) begin
            if (fq.size() == 0) chk("frame_err_unexpected", 1, 0);
            else chk("frame_err_cycle", cyc, fq.pop_front());
         end else if (fq.size() > 0 && fq[0] < cyc) begin
            chk("frame_err_missing", cyc, fq.pop_front());
         end
         prev_rdy = bus.cmd_rdy;
      end
   end

   initial begin
      int base;
      logic [7:0] h, l;
      bus.tx_done = 0;
      apply_reset();
      chk("reset_cmd", 32'(bus.cmd), 32'h0000);
      chk("reset_cmd_rdy", 32'(bus.cmd_rdy), 0);
      chk("reset_trmt", 32'(bus.trmt), 0);
      chk("reset_clr_rx_rdy", 32'(bus.clr_rx_rdy), 0);
      chk("reset_frame_err", 32'(bus.frame_err), 0);
      rst_n = 1'b1;
      idle(2, 0);

      // pair assembly and cmd_rdy latency
      step(1, 8'h41, 0, 0);
      chk("t1_rdy_low_between", 32'(bus.cmd_rdy), 0);
      step(1, 8'h2F, 0, 0);
      chk("t1_cmd", 32'(bus.cmd), 32'h412F);
      chk("t1_cmd_rdy", 32'(bus.cmd_rdy), 1);

      // clear, then low-byte capture colliding with clear
      step(0, 8'h00, 1, 0);
      chk("t2_rdy_cleared", 32'(bus.cmd_rdy), 0);
      chk("t2_cmd_held", 32'(bus.cmd), 32'h412F);
      step(1, 8'h12, 0, 0);
      step(1, 8'h34, 1, 0);
      chk("t2_set_wins", 32'(bus.cmd_rdy), 1);
      step(0, 8'h00, 1, 0);

      // acknowledge: idle launch, then two requests merged while busy
      base = trmt_seen;
      step(0, 8'h00, 0, 1);
      chk("t3_trmt_now", 32'(bus.trmt), 1);
      chk("t3_tx_data", 32'(bus.tx_data), 32'hA5);
      idle(1, 0);
      step(0, 8'h00, 0, 1);
      idle(1, 0);
      step(0, 8'h00, 0, 1);
      idle(3 * L, 0);
      chk("t3_trmt_count", 32'(trmt_seen - base), 2);

      // reset with only the high byte received
      step(1, 8'h77, 0, 0);
      apply_reset();
      rst_n = 1'b1;
      idle(1, 0);
      step(1, 8'h60, 0, 0);
      step(1, 8'h00, 0, 0);
      chk("t4_cmd", 32'(bus.cmd), 32'h6000);
      step(0, 8'h00, 1, 0);

`ifdef CMD_TIMEOUT_EN
      step(1, 8'h50, 0, 0);
      idle(TMO + 2, 0);
      step(1, 8'h20, 0, 0);
      step(1, 8'h00, 0, 0);
      chk("t5_cmd", 32'(bus.cmd), 32'h2000);
      step(0, 8'h00, 1, 0);
`else
      step(1, 8'h33, 0, 0);
      idle(10000, 0);
      step(1, 8'h11, 0, 0);
      chk("t6_low_byte", 32'(bus.cmd[7:0]), 32'h11);
      chk("t6_high_byte", 32'(bus.cmd[15:8]), 32'h33);
      step(0, 8'h00, 1, 0);
`endif

      // randomized traffic with interleaved acknowledge requests
      for (int i = 0; i < 150; i++) begin
         h = 8'($urandom);
         l = 8'($urandom);
         step(1, h, 0, $urandom_range(3) == 0);
         idle($urandom_range(5), 1);
         step(1, l, $urandom_range(7) == 0, $urandom_range(3) == 0);
         idle($urandom_range(3), 1);
         if ($urandom_range(3) != 0) step(0, 8'h00, 1, $urandom_range(3) == 0);
      end

      idle(4 * L, 0);
      chk("end_trmt_queue", 32'(tq.size()), 0);
      chk("end_cmd_queue", 32'(cq_t.size()), 0);
      chk("end_frame_err_queue", 32'(fq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
